// File: rtl/nibble_pkg.sv
// Shared types for the nibble-serial adder: nibble width, nibble type and FSM states.
package nibble_pkg;

  localparam int NIBBLE_W = 4;

  typedef logic [NIBBLE_W-1:0] nibble_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_add4.sv
// 4-bit combinational ripple-carry adder; the only adder in the serial datapath.
module nibble_add4
  import nibble_pkg::*;
(
  input  nibble_t a,
  input  nibble_t b,
  input  logic    cin,
  output nibble_t s,
  output logic    cout
);

  logic [NIBBLE_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Nibble-serial W-bit adder: one nibble per cycle through a shared 4-bit adder.
// Optional ovf output is built when NIBBLE_SERIAL_OVF_FLAG_EN is defined.
//
// Handshakes: an input transfer happens on a rising edge where in_valid && in_ready;
// an output transfer happens on a rising edge where out_valid && out_ready. Producers
// hold their payload stable while valid is high and not yet accepted.
module nibble_serial_adder
  import nibble_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0]   a,
  input  logic [NIBBLE_W*NIBBLES-1:0]   b,
  input  logic                          cin,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0]   sum,
  output state_t                        state,
  output logic                          cout
`ifdef NIBBLE_SERIAL_OVF_FLAG_EN
  ,
  output logic                          ovf
`endif
);

  localparam int W = NIBBLE_W * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t           state_q;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;

  nibble_t nib_a;
  nibble_t nib_b;
  nibble_t nib_s;
  logic    nib_c;

  assign nib_a = a_q[int'(idx)*NIBBLE_W +: NIBBLE_W];
  assign nib_b = b_q[int'(idx)*NIBBLE_W +: NIBBLE_W];
  assign state = state_q;

  nibble_add4 u_add4 (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry),
    .s    (nib_s),
    .cout (nib_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
`ifdef NIBBLE_SERIAL_OVF_FLAG_EN
      ovf       <= 1'b0;
`endif
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            carry    <= cin;
            idx      <= '0;
            in_ready <= 1'b0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          sum[int'(idx)*NIBBLE_W +: NIBBLE_W] <= nib_s;
          carry <= nib_c;
          // Final nibble: latch the flags and hold idx so it never wraps.
          if (idx == LAST_IDX) begin
            cout      <= nib_c;
`ifdef NIBBLE_SERIAL_OVF_FLAG_EN
            ovf       <= nib_a[NIBBLE_W-1] ^ nib_b[NIBBLE_W-1] ^ nib_s[NIBBLE_W-1] ^ nib_c;
`endif
            out_valid <= 1'b1;
            state_q   <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state_q   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: directed literal cases plus randomized back-to-back traffic
// checked every cycle against a transaction-level model.
module tb_nibble_serial_adder;
  import nibble_pkg::*;

  localparam int NIBBLES = 4;
  localparam int W = NIBBLE_W * NIBBLES;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  state_t       state;
  logic         cout;
`ifdef NIBBLE_SERIAL_OVF_FLAG_EN
  logic         ovf;
`endif

  nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .state     (state),
    .cout      (cout)
`ifdef NIBBLE_SERIAL_OVF_FLAG_EN
    ,
    .ovf       (ovf)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Result packed as {ovf, cout, sum}; sum/cout from plain wide arithmetic,
  // ovf from the operand/result sign rule.
  function automatic logic [W+1:0] model_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic ci);
    logic [W:0] full;
    logic       o;
    full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    o = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
    return {o, full};
  endfunction

  logic [W+1:0] exp_q[$];
  logic         m_free  = 1'b1;
  logic         m_valid = 1'b0;
  int           m_left  = 0;
  logic [W+1:0] m_res   = '0;
  logic         checking = 1'b0;
  logic         q_underflow = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_free  = 1'b1;
      m_valid = 1'b0;
      m_left  = 0;
      m_res   = '0;
      exp_q.delete();
    end else if (m_free) begin
      if (in_valid) begin
        exp_q.push_back(model_add(a, b, cin));
        m_free = 1'b0;
        m_left = NIBBLES;
      end
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        if (exp_q.size() > 0) m_res = exp_q.pop_front();
        else q_underflow = 1'b1;
        m_valid = 1'b1;
      end
    end else if (out_ready) begin
      m_valid = 1'b0;
      m_free  = 1'b1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (checking) begin
      check("in_ready", {31'd0, in_ready}, {31'd0, m_free});
      check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      check("state_idle", {31'd0, state == IDLE}, {31'd0, m_free});
      if (m_free || m_valid) begin
        check("sum", {{(32-W){1'b0}}, sum}, {{(32-W){1'b0}}, m_res[W-1:0]});
        check("cout", {31'd0, cout}, {31'd0, m_res[W]});
`ifdef NIBBLE_SERIAL_OVF_FLAG_EN
        check("ovf", {31'd0, ovf}, {31'd0, m_res[W+1]});
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic ci, input int hold, input logic noise,
                       input logic [W-1:0] exp_sum, input logic exp_cout, input logic exp_ovf);
    int lat;
    check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    a = x; b = y; cin = ci; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (noise) in_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, NIBBLES);
    check({tag, "_sum"}, {{(32-W){1'b0}}, sum}, {{(32-W){1'b0}}, exp_sum});
    check({tag, "_cout"}, {31'd0, cout}, {31'd0, exp_cout});
`ifdef NIBBLE_SERIAL_OVF_FLAG_EN
    check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
`else
    if (exp_ovf === 1'bx) $display("note: %s unexpected x", tag);
`endif
    for (int i = 0; i < hold; i++) begin
      if (noise) in_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_hold_sum"}, {{(32-W){1'b0}}, sum}, {{(32-W){1'b0}}, exp_sum});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_back_idle"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_valid_low"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_retained"}, {{(32-W){1'b0}}, sum}, {{(32-W){1'b0}}, exp_sum});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic acc;
    int   guard;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checking = 1'b1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_sum", {{(32-W){1'b0}}, sum}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_op("add_1234", 16'h1234, 16'h0FFF, 1'b0, 0, 1'b0, 16'h2233, 1'b0, 1'b0);
    do_op("add_ffff", 16'hFFFF, 16'h0001, 1'b0, 1, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op("add_cin",  16'h0000, 16'h0000, 1'b1, 0, 1'b0, 16'h0001, 1'b0, 1'b0);
    do_op("add_7fff", 16'h7FFF, 16'h0001, 1'b0, 0, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op("backpres", 16'hA5C3, 16'h5A3D, 1'b1, 5, 1'b1, 16'h0001, 1'b1, 1'b0);

    // Reset landing on the second RUN cycle.
    a = 16'hFFFF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrun_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrun_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrun_sum", {{(32-W){1'b0}}, sum}, 32'd0);
    check("midrun_cout", {31'd0, cout}, 32'd0);
    do_op("after_rst", 16'h0001, 16'h0001, 1'b0, 0, 1'b0, 16'h0002, 1'b0, 1'b0);

    // Back-to-back random traffic with in_valid held and random backpressure.
    for (int k = 0; k < 16; k++) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom_range(0, 1));
      if (k == 3) begin a = 16'h8000; b = 16'h8000; end
      if (k == 4) begin a = 16'h4000; b = 16'h4000; end
      in_valid = 1'b1;
      acc = 1'b0;
      guard = 0;
      while (!acc && guard < 100) begin
        out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
        guard++;
      end
      check("b2b_accepted", {31'd0, acc}, 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (!in_ready && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    check("drain_idle", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b0;
    @(posedge clk); #1;
    check("model_queue_ok", {31'd0, q_underflow}, 32'd0);
    check("model_queue_empty", exp_q.size(), 32'd0);

    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, meaning number of 4-bit nibbles per operand (operand width W = 4*NIBBLES, legal range 2..8).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1, operand request.
REQ-005 SHALL have port in_ready, output, 1, block can accept operands.
REQ-006 SHALL have ports a and b, input, W each, addend operands.
REQ-007 SHALL have port cin, input, 1, carry into nibble 0.
REQ-008 SHALL have port out_valid, output, 1, result available.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-010 SHALL have port sum, output, W, registered result.
REQ-011 SHALL have port cout, output, 1, carry out of the top nibble.
REQ-012 SHALL have port ovf, output, 1, two's-complement overflow (only with OVF_FLAG_EN).

Function
REQ-013 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-014 In IDLE: in_ready=1, out_valid=0; on in_valid=1, SHALL capture a, b, cin, clear the nibble index to 0, and enter RUN.
REQ-015 In RUN: each cycle SHALL add nibble idx of a and b plus the carry register through one 4-bit adder, write the 4-bit result into sum[4*idx+3:4*idx], store the carry, and increment idx.
REQ-016 After the RUN cycle with idx=NIBBLES-1, SHALL enter DONE; the index SHALL never wrap past NIBBLES-1.
REQ-017 Latency: acceptance at edge T; out_valid SHALL be 1 after edge T+NIBBLES (exactly NIBBLES RUN cycles).
REQ-018 In DONE: out_valid=1, and sum/cout/ovf SHALL hold stable until out_ready=1, then return to IDLE on that edge.
REQ-019 in_ready SHALL be 0 in RUN and DONE; in_valid outside IDLE SHALL be ignored (no queueing, no same-cycle accept in DONE).
REQ-020 Result SHALL equal (a + b + cin) mod 2^W, with cout = bit W of the full sum.
REQ-021 sum, cout, ovf SHALL retain the last result after leaving DONE until the next acceptance.

Reset
REQ-022 rst=1 at an edge SHALL force IDLE, idx=0, carry=0, sum=0, cout=0, ovf=0, out_valid=0, in_ready=1 after that edge, from any state, including mid-RUN.
REQ-023 rst SHALL take priority over in_valid and out_ready in the same cycle.

Configuration
REQ-024 With macro NIBBLE_SERIAL_OVF_FLAG_EN defined, port ovf SHALL exist and equal (carry into MSB) XOR (carry out of MSB) of the final nibble, registered with cout.
REQ-025 Without NIBBLE_SERIAL_OVF_FLAG_EN, port ovf and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-026 Shared package nibble_pkg SHALL hold NIBBLE_W=4, the FSM state enum typedef (IDLE, RUN, DONE), and the nibble type.
REQ-027 The per-cycle add SHALL be one instance of sub-module nibble_add4 (4-bit combinational ripple adder: a, b, cin -> s, cout); no other adder logic.
REQ-028 Index counter width SHALL be $clog2(NIBBLES).

Verification (NIBBLES=4)
REQ-029 a=0x1234, b=0x0FFF, cin=0 -> after 4 RUN cycles sum=0x2233, cout=0, ovf=0.
REQ-030 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; a=0x0000, b=0x0000, cin=1 -> sum=0x0001, cout=0.
REQ-031 a=0x7FFF, b=0x0001, cin=0 with macro -> sum=0x8000, cout=0, ovf=1; without macro, the build has no ovf port.
REQ-032 Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and sum held for 5 cycles; in_valid pulses during RUN/DONE ignored; return to IDLE one edge after out_ready=1.
REQ-033 rst=1 at the 2nd RUN cycle of 0xFFFF+0x0001 -> next cycle IDLE, sum=0, cout=0, in_ready=1; the following 0x0001+0x0001 yields sum=0x0002.
REQ-034 Back-to-back: new in_valid held high through completion -> accepted on the first IDLE cycle after DONE handshake; out_valid first asserted 4 cycles after each acceptance.
